serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_addsub.sv | 99 +++++++++
 tb/tb_serial_addsub.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder used for each serial bit position.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first: one word per WIDTH cycles with a
// parallel result, carry and signed overflow reported on a done pulse.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             in_A,
  input  logic             in_B,
  output logic             sum_bit,
  output logic [WIDTH-1:0] sum_word,
  output logic             carry_out,
  output logic             overflow,
  output logic             done,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             mode_q;
  logic [WIDTH-1:0] shreg;

  logic accept, active, eff_mode, cin, b_eff, s, co;

  // Bit 0 is processed in the accepting cycle, so it uses the live mode
  // input for both the B inversion and the carry-in.
  assign accept   = (state == IDLE) && start;
  assign active   = accept || (state == RUN);
  assign eff_mode = (state == IDLE) ? mode : mode_q;
  assign cin      = (state == IDLE) ? (mode == MODE_SUB) : carry;
  assign b_eff    = in_B ^ eff_mode;
  assign busy     = (state == RUN);

  full_adder_cell u_fa (
    .a   (in_A),
    .b   (b_eff),
    .cin (cin),
    .sum (s),
    .cout(co)
  );

  // NOTE: every register here uses non-blocking assignment so all state
  // samples the pre-edge values; blocking would chain updates in one edge.
  // NOTE: the shift register is reset explicitly because it is a handful of
  // flops, not a RAM; a partial word must never surface after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      mode_q    <= MODE_ADD;
      shreg     <= '0;
      sum_bit   <= 1'b0;
      sum_word  <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (active) begin
        sum_bit <= s;
        carry   <= co;
        shreg   <= {s, shreg[WIDTH-1:1]};
      end
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            cnt    <= CW'(1);
            state  <= RUN;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            sum_word  <= {s, shreg[WIDTH-1:1]};
            carry_out <= co;
            overflow  <= cin ^ co;
            done      <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: directed corner words, mid-word start
// and reset, then randomized words against an arithmetic reference model.
module tb_serial_addsub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         in_A = 1'b0;
  logic         in_B = 1'b0;
  logic         sum_bit, carry_out, overflow, done, busy;
  logic [W-1:0] sum_word;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .in_A     (in_A),
    .in_B     (in_B),
    .sum_bit  (sum_bit),
    .sum_word (sum_word),
    .carry_out(carry_out),
    .overflow (overflow),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    exp_t e;
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (m == 1'b0) begin
      r    = ua + ub;
      sr   = sa + sb;
      e.co = (r >= (1 << W));
    end else begin
      r    = ua - ub;
      sr   = sa - sb;
      e.co = (ua >= ub);
    end
    e.sum = W'(r & ((1 << W) - 1));
    e.ov  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    e.due = 0;
    return e;
  endfunction

  // Drives one word from just after a rising edge. glitch_at raises start
  // on that bit; abort_at asserts reset during that bit and drops the word.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                           input int glitch_at, input int abort_at);
    exp_t e;
    e = model(a, b, m);
    for (int i = 0; i < W; i++) begin
      start = (i == 0) || (i == glitch_at);
      mode  = (i == 0) ? m : logic'($urandom_range(0, 1));
      in_A  = a[i];
      in_B  = b[i];
      if (i == 0 && abort_at < 0) begin
        e.due = cyc + W;
        sb_q.push_back(e);
      end
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_sum_bit", sum_bit, 0);
        check("rst_sum_word", sum_word, 0);
        check("rst_carry_out", carry_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      check($sformatf("sum_bit%0d", i), sum_bit, e.sum[i]);
      check($sformatf("busy%0d", i), busy, (i < W - 1));
    end
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      mode  = logic'($urandom_range(0, 1));
      in_A  = logic'($urandom_range(0, 1));
      in_B  = logic'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sum_word", sum_word, mon_e.sum);
        check("carry_out", carry_out, mon_e.co);
        check("overflow", overflow, mon_e.ov);
        check("done_cycle", cyc, mon_e.due);
      end
    end
  end

  initial begin
    #12;
    check("init_sum_word", sum_word, 0);
    check("init_sum_bit", sum_bit, 0);
    check("init_carry_out", carry_out, 0);
    check("init_overflow", overflow, 0);
    check("init_done", done, 0);
    check("init_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    send_word(8'h5A, 8'h25, 1'b0, -1, -1);
    idle(1);
    send_word(8'hFF, 8'h01, 1'b0, -1, -1);
    idle(1);
    send_word(8'h7F, 8'h01, 1'b0, -1, -1);
    idle(1);
    send_word(8'h10, 8'h20, 1'b1, -1, -1);
    idle(1);
    send_word(8'h80, 8'h01, 1'b1, -1, -1);
    idle(2);

    // Gapless pair: second start lands in the first word's done cycle.
    send_word(8'hFF, 8'hFF, 1'b0, -1, -1);
    send_word(8'h00, 8'h00, 1'b0, -1, -1);
    idle(2);

    send_word(8'h3C, 8'h11, 1'b0, 3, -1);
    idle(2);

    send_word(8'hAA, 8'h55, 1'b0, -1, 4);
    idle(3);
    send_word(8'h01, 8'h01, 1'b0, -1, -1);
    idle(2);

    for (int n = 0; n < 40; n++) begin
      send_word(W'($urandom), W'($urandom), logic'($urandom_range(0, 1)), -1, -1);
      idle($urandom_range(0, 2));
    end

    for (int t = 0; t < 20 && sb_q.size() != 0; t++) idle(1);
    if (sb_q.size() != 0) check("queue_drain", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
